wrr_grant_sched: RTL

WRR_GRANT_SCHED -- requirements
Module: wrr_grant_sched

---
 rtl/wrr_grant_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wrr_grant_sched.sv
// Weighted round-robin grant scheduler: per-queue credits reloaded from weights each round,
// largest remaining credit wins. Define WRR_TIE_RR_EN for rotating tie-break (else lowest index wins).
module wrr_grant_sched #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned ID_W     = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*WEIGHT_W-1:0] weight,
  input  logic [NUM_CH-1:0]          empty,
  input  logic                       grant_ready,
  output logic                       grant_valid,
  output logic [ID_W-1:0]            grant_id,
  output logic                       round_start
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SELECT = 2'd2,
    S_GRANT  = 2'd3
  } state_e;

  state_e                           state_q, state_d;
  logic [NUM_CH-1:0][WEIGHT_W-1:0]  credit_q, credit_d;
  logic                             grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]                  grant_id_q, grant_id_d;
  logic                             round_start_q, round_start_d;
`ifdef WRR_TIE_RR_EN
  logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                  idx;
  int unsigned                      idx_sum;
`endif

  logic [NUM_CH-1:0]                eligible;
  logic [NUM_CH-1:0]                cand;
  logic [ID_W-1:0]                  best_id;
  logic [WEIGHT_W-1:0]              best_cr;

  // Per-queue eligibility (has data and weight) and candidacy (has data and credit)
  always_comb begin
    eligible = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = !empty[i] && (weight[i*WEIGHT_W +: WEIGHT_W] != '0);
      cand[i]     = !empty[i] && (credit_q[i] != '0);
    end
  end

  // Largest-credit candidate; strict compare keeps the first tied queue in search order
  always_comb begin
    best_id = '0;
    best_cr = '0;
`ifdef WRR_TIE_RR_EN
    idx     = '0;
    idx_sum = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_sum = 32'(rr_ptr_q) + 32'(k);
      if (idx_sum >= NUM_CH) idx_sum = idx_sum - NUM_CH;
      idx = ID_W'(idx_sum);
      if (cand[idx] && (credit_q[idx] > best_cr)) begin
        best_cr = credit_q[idx];
        best_id = idx;
      end
    end
`else
    for (int i = 0; i < NUM_CH; i++) begin
      if (cand[i] && (credit_q[i] > best_cr)) begin
        best_cr = credit_q[i];
        best_id = ID_W'(i);
      end
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    round_start_d = 1'b0;
`ifdef WRR_TIE_RR_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_d       = S_LOAD;
          round_start_d = 1'b1;
        end
      end
      S_LOAD: begin
        credit_d = weight;
        state_d  = S_SELECT;
      end
      S_SELECT: begin
        if (|cand) begin
          grant_id_d    = best_id;
          grant_valid_d = 1'b1;
          state_d       = S_GRANT;
        end else if (|eligible) begin
          state_d       = S_LOAD;
          round_start_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // Only a candidate is granted, so this credit is non-zero
        if (grant_ready) begin
          credit_d[grant_id_q] = credit_q[grant_id_q] - WEIGHT_W'(1);
          grant_valid_d        = 1'b0;
          state_d              = S_SELECT;
`ifdef WRR_TIE_RR_EN
          rr_ptr_d = (grant_id_q == ID_W'(NUM_CH - 1)) ? '0 : grant_id_q + ID_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      round_start_q <= 1'b0;
`ifdef WRR_TIE_RR_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      round_start_q <= round_start_d;
`ifdef WRR_TIE_RR_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign round_start = round_start_q;

endmodule
